result_serializer: RTL

Downstream drain stage for the systolic-array core. It accepts one full output row per handshake (`ARRAYWIDTH` lanes × `OUTPUT_BUF_DATASIZE` bits, tagged with tile row/column indices) and buffers rows in a small FIFO. It then streams them out one lane per beat on a valid/ready interface toward the host/memory writer. It also reports completion of the final matrix row (`done`) for the board-level finish LED.

---
 rtl/result_serializer_pkg.sv | 30 +++
 rtl/result_serializer_if.sv | 35 +++
 rtl/result_row_fifo.sv | 50 +++++
 rtl/result_serializer.sv | 109 ++++++++++
 4 files changed

// File: rtl/result_serializer_pkg.sv
// Shared sizing defaults and types for the systolic-array result drain path.
// Board-level config may predefine the macros; otherwise the defaults below apply.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 8
`endif
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 32
`endif
`ifndef RESULT_FIFO_DEPTH
`define RESULT_FIFO_DEPTH 4
`endif

package result_serializer_pkg;
  localparam int ARRAYWIDTH          = `ARRAYWIDTH;
  localparam int OUTPUT_BUF_DATASIZE = `OUTPUT_BUF_DATASIZE;
  localparam int RESULT_FIFO_DEPTH   = `RESULT_FIFO_DEPTH;
  localparam int TILE_ROW_W          = 3;
  localparam int TILE_COL_W          = 5;
  localparam int ROW_COUNT_W         = 16;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

  // Lane index width; keeps a 1-bit counter legal for a single-lane array.
  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction
endpackage

// File: rtl/result_serializer_if.sv
// Row-in / lane-out stream bundle between the array drain and the host writer.
// master = row producer and beat consumer; slave = the serializer.
interface result_serializer_if
  import result_serializer_pkg::*;
#(
  parameter int LANES  = ARRAYWIDTH,
  parameter int DATA_W = OUTPUT_BUF_DATASIZE
) ();
  localparam int LANE_W = lane_width(LANES);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W*LANES-1:0] in_data;
  logic [TILE_ROW_W-1:0]   in_tile_row;
  logic [TILE_COL_W-1:0]   in_tile_col;
  logic                    in_last;

  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [LANE_W-1:0]       out_lane;
  logic [TILE_ROW_W-1:0]   out_tile_row;
  logic [TILE_COL_W-1:0]   out_tile_col;
  logic                    out_last;

  modport master (
    output in_valid, in_data, in_tile_row, in_tile_col, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_tile_row, out_tile_col, out_last
  );

  modport slave (
    input  in_valid, in_data, in_tile_row, in_tile_col, in_last, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_tile_row, out_tile_col, out_last
  );
endinterface

// File: rtl/result_row_fifo.sv
// Register-array row FIFO with a combinational head read and an occupancy count.
module result_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/result_serializer.sv
// Buffers full output rows and streams them one lane per beat to the host writer.
//   state    | meaning
//   SER_IDLE | no row loaded, out_valid low, waiting for a FIFO entry
//   SER_SEND | row in shift register, presenting lane `lane` with out_valid high
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int LANES  = ARRAYWIDTH,
  parameter int DATA_W = OUTPUT_BUF_DATASIZE,
  parameter int DEPTH  = RESULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  result_serializer_if.slave     bus,
  output logic [ROW_COUNT_W-1:0] row_count,
  output logic                   done
);
  localparam int LANE_W  = lane_width(LANES);
  localparam int ROW_W   = DATA_W * LANES;
  localparam int ENTRY_W = ROW_W + TILE_ROW_W + TILE_COL_W + 1;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  ser_state_e              state;
  logic [ROW_W-1:0]        shift_reg;
  logic [LANE_W-1:0]       lane;
  logic [TILE_ROW_W-1:0]   tag_row;
  logic [TILE_COL_W-1:0]   tag_col;
  logic                    last_tag;

  logic [ENTRY_W-1:0]      push_entry;
  logic [ENTRY_W-1:0]      head_entry;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    beat;
  logic                    final_beat;

  assign bus.in_ready = (fifo_count != CNT_W'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign push_entry   = {bus.in_data, bus.in_tile_row, bus.in_tile_col, bus.in_last};
  assign fifo_empty   = (fifo_count == '0);

  assign beat       = (state == SER_SEND) & bus.out_ready;
  assign final_beat = beat & (lane == LAST_LANE);
  // Refill on the last lane's beat keeps back-to-back rows bubble-free.
  assign pop        = ~fifo_empty & ((state == SER_IDLE) | final_beat);

  result_row_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SER_IDLE;
      shift_reg <= '0;
      lane      <= '0;
      tag_row   <= '0;
      tag_col   <= '0;
      last_tag  <= 1'b0;
      row_count <= '0;
      done      <= 1'b0;
    end else if (start) begin
      state     <= SER_IDLE;
      shift_reg <= '0;
      lane      <= '0;
      tag_row   <= '0;
      tag_col   <= '0;
      last_tag  <= 1'b0;
      row_count <= '0;
      done      <= 1'b0;
    end else begin
      if (pop) begin
        state     <= SER_SEND;
        shift_reg <= head_entry[ENTRY_W-1 -: ROW_W];
        tag_row   <= head_entry[TILE_COL_W+1 +: TILE_ROW_W];
        tag_col   <= head_entry[1 +: TILE_COL_W];
        last_tag  <= head_entry[0];
        lane      <= '0;
      end else if (final_beat) begin
        state <= SER_IDLE;
      end else if (beat) begin
        shift_reg <= shift_reg >> DATA_W;
        lane      <= lane + LANE_W'(1);
      end
      if (final_beat) row_count <= row_count + ROW_COUNT_W'(1);
      if (final_beat && last_tag) done <= 1'b1;
    end
  end

  assign bus.out_valid    = (state == SER_SEND);
  assign bus.out_data     = shift_reg[DATA_W-1:0];
  assign bus.out_lane     = lane;
  assign bus.out_tile_row = tag_row;
  assign bus.out_tile_col = tag_col;
  assign bus.out_last     = last_tag & (lane == LAST_LANE);
endmodule
